// File: rtl/ctrl_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : ctrl_pkg
//  Description : Shared definitions for the pipelined RV32I/M control unit:
//                opcode and funct7 encodings, immediate-select encodings,
//                FSM state type, control bundle layout and a helper function.
//  Revision    : 1.0  initial release
// ============================================================================
package ctrl_pkg;

    // Base opcodes that the decoder recognises as legal
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;

    // funct7 values accepted on the OP opcode
    localparam logic [6:0] F7_BASE    = 7'b0000000;
    localparam logic [6:0] F7_ALT     = 7'b0100000;
    localparam logic [6:0] F7_MULDIV  = 7'b0000001;

    // immediate_select[2:0] encodings
    localparam logic [2:0] IMM_U      = 3'b000;
    localparam logic [2:0] IMM_J      = 3'b001;
    localparam logic [2:0] IMM_I      = 3'b010;
    localparam logic [2:0] IMM_B      = 3'b011;
    localparam logic [2:0] IMM_S      = 3'b100;
    localparam logic [2:0] IMM_SHAMT  = 3'b101;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_VALID    = 2'd1,
        ST_MDU_WAIT = 2'd2
    } state_t;

    typedef struct packed {
        logic [5:0] alu_signal;
        logic       reg_file_write;
        logic [2:0] data_mem_write;
        logic [3:0] data_mem_read;
        logic [3:0] branch_control;
        logic [3:0] immediate_select;
        logic       operand_1_select;
        logic       operand_2_select;
        logic [1:0] reg_write_select;
    } ctrl_bundle_t;

    localparam int unsigned BUNDLE_W = $bits(ctrl_bundle_t);

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage
`default_nettype wire

// File: rtl/ctrl_decode.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : ctrl_decode
//  Description : Purely combinational RV32I/M decoder. Maps an instruction
//                word onto the datapath control bundle and classifies it as
//                multi-cycle MUL/DIV and/or illegal.
//  Revision    : 1.0  initial release
//  Ports       : i_instruction  instruction word
//                o_bundle       decoded control bundle
//                o_is_mdu       legal M-extension op (multi-cycle)
//                o_is_div       M op is DIV/DIVU/REM/REMU (funct3[2])
//                o_illegal      encoding is not legal
// ============================================================================
module ctrl_decode
    import ctrl_pkg::*;
#(
    parameter int M_EXT        = 1,
    parameter int ILLEGAL_TRAP = 1
) (
    input  logic [31:0]  i_instruction,
    output ctrl_bundle_t o_bundle,
    output logic         o_is_mdu,
    output logic         o_is_div,
    output logic         o_illegal
);

    logic [6:0] w_opc;
    logic [2:0] w_f3;
    logic [6:0] w_f7;
    logic       w_load, w_op_imm, w_auipc, w_store, w_op, w_lui, w_branch, w_jalr, w_jal;
    logic       w_f7_base, w_f7_alt, w_mop;
    logic       w_legal_opc, w_illegal, w_trap;
    logic       w_sub_sra, w_unsigned;
    logic       w_unused_fields;

    assign w_opc = i_instruction[6:0];
    assign w_f3  = i_instruction[14:12];
    assign w_f7  = i_instruction[31:25];

    // Register specifiers and immediate bits do not affect control decode
    assign w_unused_fields = ^{i_instruction[24:15], i_instruction[11:7]};

    assign w_load   = (w_opc == OPC_LOAD);
    assign w_op_imm = (w_opc == OPC_OP_IMM);
    assign w_auipc  = (w_opc == OPC_AUIPC);
    assign w_store  = (w_opc == OPC_STORE);
    assign w_op     = (w_opc == OPC_OP);
    assign w_lui    = (w_opc == OPC_LUI);
    assign w_branch = (w_opc == OPC_BRANCH);
    assign w_jalr   = (w_opc == OPC_JALR);
    assign w_jal    = (w_opc == OPC_JAL);

    assign w_f7_base = (w_f7 == F7_BASE);
    assign w_f7_alt  = (w_f7 == F7_ALT);
    assign w_mop     = w_op & (w_f7 == F7_MULDIV);

    assign w_legal_opc = w_load | w_op_imm | w_auipc | w_store | w_op |
                         w_lui | w_branch | w_jalr | w_jal;

    assign w_illegal = ~w_legal_opc
                     | (w_op & ~(w_f7_base | w_f7_alt | w_mop))
                     | (w_mop & (M_EXT == 0));

    // Trap masking only kills side-effecting enables; other fields stay decoded
    assign w_trap = w_illegal & (ILLEGAL_TRAP != 0);

    // SUB, SRA and SRAI share the alternate-function ALU bit with LUI
    assign w_sub_sra = (w_op & w_f7_alt & ((w_f3 == 3'b000) | (w_f3 == 3'b101)))
                     | (w_op_imm & w_f7_alt & (w_f3 == 3'b101))
                     | w_lui;

    assign w_unsigned = (w_load & ((w_f3 == 3'b100) | (w_f3 == 3'b101)))
                      | (w_op_imm & (w_f3 == 3'b011))
                      | (w_op & w_f7_base & (w_f3 == 3'b011))
                      | (w_mop & ((w_f3 == 3'b010) | (w_f3 == 3'b011) | (w_f3 == 3'b111)));

    always_comb begin
        o_bundle = '0;

        o_bundle.alu_signal[5]   = 1'b0;
        o_bundle.alu_signal[4]   = w_sub_sra;
        o_bundle.alu_signal[3]   = w_mop | w_lui;
        o_bundle.alu_signal[2:0] = (w_auipc | w_jal | w_load | w_store | w_branch) ? 3'b000 : w_f3;

        o_bundle.reg_file_write  = (w_load | w_op_imm | w_auipc | w_op | w_lui | w_jalr | w_jal) & ~w_trap;
        o_bundle.data_mem_write  = {w_store & ~w_trap, w_f3[1:0]};
        o_bundle.data_mem_read   = {w_load & ~w_trap, w_f3};
        o_bundle.branch_control  = {(w_jal | w_jalr | w_branch) & ~w_trap,
                                    (w_jal | w_jalr) ? 3'b010 : w_f3};

        if (w_lui | w_auipc) begin
            o_bundle.immediate_select[2:0] = IMM_U;
        end else if (w_jal) begin
            o_bundle.immediate_select[2:0] = IMM_J;
        end else if (w_op_imm & ((w_f3 == 3'b001) | (w_f3 == 3'b101))) begin
            o_bundle.immediate_select[2:0] = IMM_SHAMT;
        end else if (w_load | w_op_imm | w_jalr) begin
            o_bundle.immediate_select[2:0] = IMM_I;
        end else if (w_branch) begin
            o_bundle.immediate_select[2:0] = IMM_B;
        end else if (w_store) begin
            o_bundle.immediate_select[2:0] = IMM_S;
        end else begin
            o_bundle.immediate_select[2:0] = IMM_U;
        end
        o_bundle.immediate_select[3] = w_unsigned;

        o_bundle.operand_1_select = w_auipc | w_jal | w_jalr;
        o_bundle.operand_2_select = w_load | w_op_imm | w_auipc | w_store |
                                    w_lui | w_jalr | w_jal | w_branch;
        o_bundle.reg_write_select = {w_auipc | w_jal | w_jalr, ~w_load};
    end

    assign o_is_mdu  = w_mop & (M_EXT != 0);
    assign o_is_div  = w_f3[2];
    assign o_illegal = w_illegal;

endmodule
`default_nettype wire

// File: rtl/pipelined_control_unit.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : pipelined_control_unit
//  Description : Registered RV32I/M decode-and-control stage. Decodes the
//                incoming instruction, holds the control bundle in a
//                valid/ready pipeline register, stalls for multi-cycle
//                MUL/DIV and flags illegal encodings.
//  Revision    : 1.0  initial release
//  Ports       : CLK, RESET_N (async, active-low)
//                in_valid/in_ready, INSTRUCTION, in_pc   - fetch side
//                flush                                  - synchronous kill
//                out_valid/out_ready, out_pc            - execute side
//                alu_signal .. reg_write_select         - control bundle
//                mdu_busy, illegal_instr                - status
// ============================================================================
module pipelined_control_unit
    import ctrl_pkg::*;
#(
    parameter int M_EXT        = 1,
    parameter int MUL_CYCLES   = 2,
    parameter int DIV_CYCLES   = 8,
    parameter int ILLEGAL_TRAP = 1
) (
    input  logic        CLK,
    input  logic        RESET_N,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] INSTRUCTION,
    input  logic [31:0] in_pc,
    input  logic        flush,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_pc,
    output logic [5:0]  alu_signal,
    output logic        reg_file_write,
    output logic [2:0]  data_mem_write,
    output logic [3:0]  data_mem_read,
    output logic [3:0]  branch_control,
    output logic [3:0]  immediate_select,
    output logic        operand_1_select,
    output logic        operand_2_select,
    output logic [1:0]  reg_write_select,
    output logic        mdu_busy,
    output logic        illegal_instr
);

    localparam int unsigned c_cnt_w = $clog2(max_u(int'(MUL_CYCLES), int'(DIV_CYCLES)) + 1);
    localparam logic [c_cnt_w-1:0] c_mul_cycles = c_cnt_w'(MUL_CYCLES);
    localparam logic [c_cnt_w-1:0] c_div_cycles = c_cnt_w'(DIV_CYCLES);

    ctrl_bundle_t         w_dec_bundle;
    logic                 w_dec_is_mdu;
    logic                 w_dec_is_div;
    logic                 w_dec_illegal;

    state_t               r_state;
    state_t               w_state_next;
    logic [c_cnt_w-1:0]   r_count;
    logic [c_cnt_w-1:0]   w_count_next;
    logic [BUNDLE_W-1:0]  r_bundle;
    ctrl_bundle_t         w_view;
    logic [31:0]          r_pc;
    logic                 r_illegal;

    logic                 w_accept;
    logic [c_cnt_w-1:0]   w_cycles;
    state_t               w_target_state;
    logic [c_cnt_w-1:0]   w_target_count;

    ctrl_decode #(
        .M_EXT        (M_EXT),
        .ILLEGAL_TRAP (ILLEGAL_TRAP)
    ) u_decode (
        .i_instruction (INSTRUCTION),
        .o_bundle      (w_dec_bundle),
        .o_is_mdu      (w_dec_is_mdu),
        .o_is_div      (w_dec_is_div),
        .o_illegal     (w_dec_illegal)
    );

    // Only combinational input-to-output path: out_ready/flush -> in_ready
    assign in_ready = ~flush & ((r_state == ST_IDLE) | ((r_state == ST_VALID) & out_ready));
    assign w_accept = in_valid & in_ready;

    // Where a freshly accepted instruction lands. A one-cycle MDU op skips
    // the wait state so it issues with the same latency as a plain op.
    assign w_cycles = w_dec_is_div ? c_div_cycles : c_mul_cycles;

    always_comb begin
        w_target_state = ST_VALID;
        w_target_count = '0;
        if (w_dec_is_mdu && (w_cycles != c_cnt_w'(1))) begin
            w_target_state = ST_MDU_WAIT;
            w_target_count = w_cycles - c_cnt_w'(1);
        end
    end

    // State register
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_state <= ST_IDLE;
            r_count <= '0;
        end else begin
            r_state <= w_state_next;
            r_count <= w_count_next;
        end
    end

    // Next-state logic; flush overrides everything
    always_comb begin
        w_state_next = r_state;
        w_count_next = r_count;
        if (flush) begin
            w_state_next = ST_IDLE;
            w_count_next = '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        w_state_next = w_target_state;
                        w_count_next = w_target_count;
                    end
                end
                ST_MDU_WAIT: begin
                    if (r_count == '0) begin
                        w_state_next = ST_VALID;
                    end else begin
                        w_count_next = r_count - c_cnt_w'(1);
                    end
                end
                ST_VALID: begin
                    if (out_ready) begin
                        if (w_accept) begin
                            w_state_next = w_target_state;
                            w_count_next = w_target_count;
                        end else begin
                            w_state_next = ST_IDLE;
                        end
                    end
                end
                default: begin
                    w_state_next = ST_IDLE;
                    w_count_next = '0;
                end
            endcase
        end
    end

    // Pipeline register: captured only on accept, so the bundle stays put
    // through the MDU wait and any out_ready stall.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_bundle  <= '0;
            r_pc      <= '0;
            r_illegal <= 1'b0;
        end else if (w_accept) begin
            r_bundle  <= w_dec_bundle;
            r_pc      <= in_pc;
            r_illegal <= w_dec_illegal;
        end
    end

    assign w_view = ctrl_bundle_t'(r_bundle);

    // Output logic
    always_comb begin
        out_valid        = (r_state == ST_VALID);
        mdu_busy         = (r_state == ST_MDU_WAIT);
        illegal_instr    = r_illegal & (r_state == ST_VALID);
        out_pc           = r_pc;
        alu_signal       = w_view.alu_signal;
        reg_file_write   = w_view.reg_file_write;
        data_mem_write   = w_view.data_mem_write;
        data_mem_read    = w_view.data_mem_read;
        branch_control   = w_view.branch_control;
        immediate_select = w_view.immediate_select;
        operand_1_select = w_view.operand_1_select;
        operand_2_select = w_view.operand_2_select;
        reg_write_select = w_view.reg_write_select;
    end

endmodule
`default_nettype wire

// File: tb/tb_pipelined_control_unit.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_pipelined_control_unit
//  Description : Self-checking bench for pipelined_control_unit. Directed
//                scenarios followed by randomized traffic compared against a
//                transaction-level reference model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_pipelined_control_unit;

    localparam int MULC = 4;
    localparam int DIVC = 8;

    localparam logic [31:0] I_ADD  = 32'h00B50533;
    localparam logic [31:0] I_DIV  = 32'h02B54533;
    localparam logic [31:0] I_MUL  = 32'h02B50533;
    localparam logic [31:0] I_LW   = 32'h0005A503;
    localparam logic [31:0] I_SW   = 32'h00A5A023;
    localparam logic [31:0] I_ADDI = 32'h00150513;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // main instance (M extension enabled)
    logic        in_valid = 1'b0, flush = 1'b0, out_ready = 1'b0;
    logic [31:0] instruction = '0, in_pc = '0;
    logic        in_ready, out_valid, reg_file_write, operand_1_select, operand_2_select;
    logic        mdu_busy, illegal_instr;
    logic [31:0] out_pc;
    logic [5:0]  alu_signal;
    logic [2:0]  data_mem_write;
    logic [3:0]  data_mem_read, branch_control, immediate_select;
    logic [1:0]  reg_write_select;
    logic [26:0] dut_vec;

    // second instance (M extension disabled)
    logic        b_in_valid = 1'b0, b_out_ready = 1'b0;
    logic [31:0] b_instruction = '0, b_in_pc = '0;
    logic        b_in_ready, b_out_valid, b_reg_file_write, b_operand_1_select, b_operand_2_select;
    logic        b_mdu_busy, b_illegal_instr;
    logic [31:0] b_out_pc;
    logic [5:0]  b_alu_signal;
    logic [2:0]  b_data_mem_write;
    logic [3:0]  b_data_mem_read, b_branch_control, b_immediate_select;
    logic [1:0]  b_reg_write_select;
    logic [26:0] b_vec;

    pipelined_control_unit #(
        .M_EXT(1), .MUL_CYCLES(MULC), .DIV_CYCLES(DIVC), .ILLEGAL_TRAP(1)
    ) dut (
        .CLK(clk), .RESET_N(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .INSTRUCTION(instruction), .in_pc(in_pc), .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
        .alu_signal(alu_signal), .reg_file_write(reg_file_write),
        .data_mem_write(data_mem_write), .data_mem_read(data_mem_read),
        .branch_control(branch_control), .immediate_select(immediate_select),
        .operand_1_select(operand_1_select), .operand_2_select(operand_2_select),
        .reg_write_select(reg_write_select), .mdu_busy(mdu_busy),
        .illegal_instr(illegal_instr)
    );

    pipelined_control_unit #(
        .M_EXT(0), .MUL_CYCLES(MULC), .DIV_CYCLES(DIVC), .ILLEGAL_TRAP(1)
    ) dut_b (
        .CLK(clk), .RESET_N(rst_n), .in_valid(b_in_valid), .in_ready(b_in_ready),
        .INSTRUCTION(b_instruction), .in_pc(b_in_pc), .flush(1'b0),
        .out_valid(b_out_valid), .out_ready(b_out_ready), .out_pc(b_out_pc),
        .alu_signal(b_alu_signal), .reg_file_write(b_reg_file_write),
        .data_mem_write(b_data_mem_write), .data_mem_read(b_data_mem_read),
        .branch_control(b_branch_control), .immediate_select(b_immediate_select),
        .operand_1_select(b_operand_1_select), .operand_2_select(b_operand_2_select),
        .reg_write_select(b_reg_write_select), .mdu_busy(b_mdu_busy),
        .illegal_instr(b_illegal_instr)
    );

    assign dut_vec = {alu_signal, reg_file_write, data_mem_write, data_mem_read, branch_control,
                      immediate_select, operand_1_select, operand_2_select, reg_write_select,
                      illegal_instr};
    assign b_vec   = {b_alu_signal, b_reg_file_write, b_data_mem_write, b_data_mem_read,
                      b_branch_control, b_immediate_select, b_operand_1_select,
                      b_operand_2_select, b_reg_write_select, b_illegal_instr};

    typedef struct packed {
        logic [5:0] alu;
        logic       rfw;
        logic [2:0] dmw;
        logic [3:0] dmr;
        logic [3:0] bc;
        logic [3:0] imm;
        logic       op1;
        logic       op2;
        logic [1:0] rws;
        logic       ill;
    } exp_t;

    int tests = 0;
    int fails = 0;

    // reference model state: at most one instruction in the stage
    bit          m_has = 1'b0;
    int          m_ready_at = 0;
    exp_t        m_b;
    logic [31:0] m_pc;
    int          cyc = 0;

    // Expected control bundle, written straight from the instruction-class rules
    function automatic exp_t ref_decode(input logic [31:0] ins, input bit mext);
        exp_t e;
        logic [6:0] opc;
        logic [2:0] f3;
        logic [6:0] f7;
        bit ld, oi, au, st, op, lu, br, jr, jl, mop, ill;
        opc = ins[6:0]; f3 = ins[14:12]; f7 = ins[31:25];
        ld = (opc == 7'h03); oi = (opc == 7'h13); au = (opc == 7'h17);
        st = (opc == 7'h23); op = (opc == 7'h33); lu = (opc == 7'h37);
        br = (opc == 7'h63); jr = (opc == 7'h67); jl = (opc == 7'h6F);
        mop = op && (f7 == 7'h01);
        ill = !(ld || oi || au || st || op || lu || br || jr || jl)
            || (op && !(f7 == 7'h00 || f7 == 7'h20 || f7 == 7'h01))
            || (mop && !mext);
        e = '0;
        e.alu[4] = (op && f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5)) || (oi && f3 == 3'd5 && f7 == 7'h20) || lu;
        e.alu[3] = mop || lu;
        e.alu[2:0] = (au || jl || ld || st || br) ? 3'd0 : f3;
        e.rfw = (ld || oi || au || op || lu || jr || jl) && !ill;
        e.dmw = {st && !ill, f3[1:0]};
        e.dmr = {ld && !ill, f3};
        e.bc  = {(jl || jr || br) && !ill, (jl || jr) ? 3'b010 : f3};
        if (lu || au)                          e.imm[2:0] = 3'd0;
        else if (jl)                           e.imm[2:0] = 3'd1;
        else if (oi && (f3 == 3'd1 || f3 == 3'd5)) e.imm[2:0] = 3'd5;
        else if (ld || oi || jr)               e.imm[2:0] = 3'd2;
        else if (br)                           e.imm[2:0] = 3'd3;
        else if (st)                           e.imm[2:0] = 3'd4;
        else                                   e.imm[2:0] = 3'd0;
        e.imm[3] = (ld && (f3 == 3'd4 || f3 == 3'd5)) || (oi && f3 == 3'd3)
                || (op && f7 == 7'h00 && f3 == 3'd3)
                || (mop && (f3 == 3'd2 || f3 == 3'd3 || f3 == 3'd7));
        e.op1 = au || jl || jr;
        e.op2 = ld || oi || au || st || lu || jr || jl || br;
        e.rws = {au || jl || jr, !ld};
        e.ill = ill;
        return e;
    endfunction

    // Number of cycles an accepted instruction spends stalled before issue
    function automatic int ref_busy(input logic [31:0] ins);
        int c;
        if (ins[6:0] == 7'h33 && ins[31:25] == 7'h01) begin
            c = ins[14] ? DIVC : MULC;
            return (c > 1) ? c : 0;
        end
        return 0;
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [6:0]  opcs [9] = '{7'h03, 7'h13, 7'h17, 7'h23, 7'h33, 7'h37, 7'h63, 7'h67, 7'h6F};
        logic [6:0]  f7s  [3] = '{7'h00, 7'h20, 7'h01};
        logic [31:0] r;
        int unsigned k;
        r = $urandom;
        k = $urandom_range(0, 15);
        if (k == 0) return 32'h0;
        if (k == 1) return r;
        if (k <= 4) begin
            r[6:0] = 7'h33;
            if (k != 4) r[31:25] = f7s[$urandom_range(0, 2)];
            return r;
        end
        r[6:0] = opcs[$urandom_range(0, 8)];
        if ($urandom_range(0, 1) == 1) r[31:25] = 7'h20;
        return r;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_model(input logic fl, input logic ordy);
        bit ev, eb, er;
        ev = m_has && (cyc >= m_ready_at);
        eb = m_has && (cyc < m_ready_at);
        er = !fl && (!m_has || (ev && ordy));
        chk("in_ready", {31'b0, in_ready}, {31'b0, er});
        chk("out_valid", {31'b0, out_valid}, {31'b0, ev});
        chk("mdu_busy", {31'b0, mdu_busy}, {31'b0, eb});
        if (ev) begin
            chk("out_pc", out_pc, m_pc);
            chk("bundle", {5'b0, dut_vec}, {5'b0, m_b});
        end else begin
            chk("illegal_qual", {31'b0, illegal_instr}, 32'h0);
        end
    endtask

    // One clock cycle: drive at negedge, check mid-cycle, advance model at posedge
    task automatic cycle(input logic v, input logic [31:0] ins, input logic [31:0] pc,
                         input logic ordy, input logic fl);
        bit ev, er;
        @(negedge clk);
        in_valid = v; instruction = ins; in_pc = pc; out_ready = ordy; flush = fl;
        #1;
        check_model(fl, ordy);
        ev = m_has && (cyc >= m_ready_at);
        er = !fl && (!m_has || (ev && ordy));
        @(posedge clk);
        cyc++;
        if (fl) begin
            m_has = 1'b0;
        end else begin
            if (ev && ordy) m_has = 1'b0;
            if (v && er) begin
                m_has      = 1'b1;
                m_b        = ref_decode(ins, 1'b1);
                m_pc       = pc;
                m_ready_at = cyc + ref_busy(ins);
            end
        end
    endtask

    initial begin
        exp_t eb;

        // reset values
        #12;
        chk("rst_in_ready", {31'b0, in_ready}, 32'h1);
        chk("rst_out_valid", {31'b0, out_valid}, 32'h0);
        chk("rst_mdu_busy", {31'b0, mdu_busy}, 32'h0);
        chk("rst_out_pc", out_pc, 32'h0);
        chk("rst_bundle", {5'b0, dut_vec}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // M_EXT=0: MUL issues next cycle as illegal with enables cleared
        @(negedge clk);
        b_in_valid = 1'b1; b_instruction = I_MUL; b_in_pc = 32'h0000_0040; b_out_ready = 1'b1;
        #1;
        chk("mext0_in_ready", {31'b0, b_in_ready}, 32'h1);
        @(posedge clk);
        #1;
        b_in_valid = 1'b0;
        eb = ref_decode(I_MUL, 1'b0);
        chk("mext0_valid", {31'b0, b_out_valid}, 32'h1);
        chk("mext0_illegal", {31'b0, b_illegal_instr}, 32'h1);
        chk("mext0_busy", {31'b0, b_mdu_busy}, 32'h0);
        chk("mext0_rfw", {31'b0, b_reg_file_write}, 32'h0);
        chk("mext0_enables", {29'b0, b_data_mem_write[2], b_data_mem_read[3], b_branch_control[3]}, 32'h0);
        chk("mext0_pc", b_out_pc, 32'h0000_0040);
        chk("mext0_bundle", {5'b0, b_vec}, {5'b0, eb});

        // ADD: one-cycle issue
        cycle(1'b1, I_ADD, 32'h100, 1'b1, 1'b0);
        #1;
        chk("add_valid", {31'b0, out_valid}, 32'h1);
        chk("add_alu", {26'b0, alu_signal}, 32'h0);
        chk("add_rfw", {31'b0, reg_file_write}, 32'h1);
        chk("add_op2", {31'b0, operand_2_select}, 32'h0);

        // DIV: eight stall cycles, then issue
        cycle(1'b1, I_DIV, 32'h104, 1'b1, 1'b0);
        #1;
        chk("div_busy", {31'b0, mdu_busy}, 32'h1);
        chk("div_in_ready", {31'b0, in_ready}, 32'h0);
        for (int i = 0; i < DIVC; i++) cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        #1;
        chk("div_valid", {31'b0, out_valid}, 32'h1);
        chk("div_alu3", {31'b0, alu_signal[3]}, 32'h1);

        // LW then SW back-to-back with no bubble
        cycle(1'b1, I_LW, 32'h108, 1'b1, 1'b0);
        #1;
        chk("lw_valid", {31'b0, out_valid}, 32'h1);
        chk("lw_pc", out_pc, 32'h108);
        cycle(1'b1, I_SW, 32'h10C, 1'b1, 1'b0);
        #1;
        chk("sw_valid", {31'b0, out_valid}, 32'h1);
        chk("sw_pc", out_pc, 32'h10C);
        chk("sw_dmw", {29'b0, data_mem_write}, 32'h6);
        chk("sw_rfw", {31'b0, reg_file_write}, 32'h0);

        // back-pressure: bundle must hold for five cycles
        cycle(1'b1, I_ADDI, 32'h110, 1'b1, 1'b0);
        for (int i = 0; i < 5; i++) cycle(1'b1, I_ADD, 32'h200, 1'b0, 1'b0);
        #1;
        chk("hold_pc", out_pc, 32'h110);
        chk("hold_valid", {31'b0, out_valid}, 32'h1);
        cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

        // flush in the third stall cycle of a MUL
        cycle(1'b1, I_MUL, 32'h114, 1'b1, 1'b0);
        cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b1);
        #1;
        flush = 1'b0;
        #1;
        chk("flush_valid", {31'b0, out_valid}, 32'h0);
        chk("flush_busy", {31'b0, mdu_busy}, 32'h0);
        chk("flush_in_ready", {31'b0, in_ready}, 32'h1);

        // all-zero word is illegal
        cycle(1'b1, 32'h0, 32'h118, 1'b1, 1'b0);
        #1;
        chk("zero_illegal", {31'b0, illegal_instr}, 32'h1);
        chk("zero_rfw", {31'b0, reg_file_write}, 32'h0);
        chk("zero_enables", {29'b0, data_mem_write[2], data_mem_read[3], branch_control[3]}, 32'h0);

        // randomized traffic against the reference model
        for (int i = 0; i < 400; i++) begin
            cycle($urandom_range(0, 3) != 0, rand_instr(), $urandom,
                  $urandom_range(0, 3) != 0, $urandom_range(0, 19) == 0);
        end

        // asynchronous reset in the middle of a DIV
        cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b1);
        cycle(1'b1, I_DIV, 32'h300, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        #2;
        chk("pre_arst_busy", {31'b0, mdu_busy}, 32'h1);
        rst_n = 1'b0;
        #1;
        chk("arst_busy", {31'b0, mdu_busy}, 32'h0);
        chk("arst_valid", {31'b0, out_valid}, 32'h0);
        chk("arst_pc", out_pc, 32'h0);
        chk("arst_bundle", {5'b0, dut_vec}, 32'h0);
        chk("arst_in_ready", {31'b0, in_ready}, 32'h1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
